// File: rtl/frame_line_ring.sv
// Multi-line frame capture ring: stores one triggered frame's lines into LINES line slots, read back per line with row tags.
// Optional FRAME_LINE_RING_DROP_CNT_EN adds a 16-bit saturating dropped-line counter on drop_cnt.
module frame_line_ring #(
  parameter int H_ACT  = 1280,
  parameter int V_ACT  = 720,
  parameter int DATA_W = 16,
  parameter int LINES  = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       trig,
  input  logic                       vsync,
  input  logic                       de,
  input  logic [DATA_W-1:0]          din,
  output logic                       ready,
  input  logic                       read_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       rd_last,
  output logic [$clog2(V_ACT)-1:0]   rd_row,
  output logic                       busy,
`ifdef FRAME_LINE_RING_DROP_CNT_EN
  output logic [15:0]                drop_cnt,
`endif
  output logic                       error
);

  localparam int XW = $clog2(H_ACT);
  localparam int RW = $clog2(V_ACT);
  localparam int SW = $clog2(LINES);
  localparam int CW = SW + 1;
  localparam int AW = $clog2(LINES * H_ACT);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_VS = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              vsync_d_q, vsync_d_d;
  logic [XW-1:0]     wr_x_q, wr_x_d;
  logic [RW-1:0]     wr_y_q, wr_y_d;
  logic [SW-1:0]     wr_ptr_q, wr_ptr_d;
  logic              drop_line_q, drop_line_d;
  logic [XW-1:0]     rd_x_q, rd_x_d;
  logic [SW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              error_q, error_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic [RW-1:0]     rd_row_q, rd_row_d;
  logic [RW-1:0]     tag_q [LINES];
  logic [RW-1:0]     tag_d [LINES];
  logic [DATA_W-1:0] rd_data_q;
`ifdef FRAME_LINE_RING_DROP_CNT_EN
  logic [15:0]       drop_cnt_q, drop_cnt_d;
`endif

  logic              vs_rise, rd_fire, rd_eol, wr_eol, ring_full;
  logic              consume, commit, line_end, drop_now, wr_en;
  logic [AW-1:0]     wr_addr, rd_addr;

  logic [DATA_W-1:0] mem [LINES*H_ACT];

  assign wr_addr = AW'(wr_ptr_q) * AW'(H_ACT) + AW'(wr_x_q);
  assign rd_addr = AW'(rd_ptr_q) * AW'(H_ACT) + AW'(rd_x_q);

  always_comb begin
    state_d     = state_q;
    vsync_d_d   = vsync;
    wr_x_d      = wr_x_q;
    wr_y_d      = wr_y_q;
    wr_ptr_d    = wr_ptr_q;
    drop_line_d = drop_line_q;
    rd_x_d      = rd_x_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    error_d     = error_q;
    rd_row_d    = rd_row_q;
    tag_d       = tag_q;
`ifdef FRAME_LINE_RING_DROP_CNT_EN
    drop_cnt_d  = drop_cnt_q;
`endif
    vs_rise   = vsync & ~vsync_d_q;
    rd_fire   = read_en & (count_q != '0);
    rd_eol    = (rd_x_q == XW'(H_ACT - 1));
    wr_eol    = (wr_x_q == XW'(H_ACT - 1));
    ring_full = (count_q == CW'(LINES));
    consume   = rd_fire & rd_eol;
    commit    = 1'b0;
    line_end  = 1'b0;
    drop_now  = 1'b0;
    wr_en     = 1'b0;

    rd_valid_d = rd_fire;
    rd_last_d  = consume;
    if (rd_fire) begin
      rd_row_d = tag_q[rd_ptr_q];
      rd_x_d   = rd_eol ? '0 : rd_x_q + XW'(1);
      if (rd_eol) rd_ptr_d = rd_ptr_q + SW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d = S_WAIT_VS;
          error_d = 1'b0;
`ifdef FRAME_LINE_RING_DROP_CNT_EN
          drop_cnt_d = '0;
`endif
        end
      end
      S_WAIT_VS: begin
        // Ring is empty here, so realigning both pointers to slot 0 loses nothing.
        if (vs_rise) begin
          state_d     = S_CAPTURE;
          wr_x_d      = '0;
          wr_y_d      = '0;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          drop_line_d = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (vs_rise) begin
          error_d     = 1'b1;
          state_d     = S_DRAIN;
          wr_x_d      = '0;
          drop_line_d = 1'b0;
        end else if (de) begin
          // Drop decision is made once, on the first pixel, and held for the line.
          drop_now = drop_line_q | ((wr_x_q == '0) & ring_full);
          if ((wr_x_q == '0) & ring_full) begin
            error_d = 1'b1;
`ifdef FRAME_LINE_RING_DROP_CNT_EN
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
`endif
          end
          wr_en = ~drop_now;
          if (wr_eol) begin
            line_end    = 1'b1;
            commit      = ~drop_now;
            wr_x_d      = '0;
            drop_line_d = 1'b0;
          end else begin
            wr_x_d      = wr_x_q + XW'(1);
            drop_line_d = drop_now;
          end
        end else if (wr_x_q != '0) begin
          line_end    = 1'b1;
          error_d     = 1'b1;
          wr_x_d      = '0;
          drop_line_d = 1'b0;
        end
        if (line_end) begin
          wr_y_d = wr_y_q + RW'(1);
          if (wr_y_q == RW'(V_ACT - 1)) state_d = S_DRAIN;
        end
        if (commit) begin
          tag_d[wr_ptr_q] = wr_y_q;
          wr_ptr_d        = wr_ptr_q + SW'(1);
        end
      end
      S_DRAIN: begin
        if (count_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (commit & ~consume)      count_d = count_q + CW'(1);
    else if (~commit & consume) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rstn)        rd_data_q <= '0;
    else if (rd_fire) rd_data_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      vsync_d_q   <= 1'b0;
      wr_x_q      <= '0;
      wr_y_q      <= '0;
      wr_ptr_q    <= '0;
      drop_line_q <= 1'b0;
      rd_x_q      <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      error_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_row_q    <= '0;
      for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
`ifdef FRAME_LINE_RING_DROP_CNT_EN
      drop_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      vsync_d_q   <= vsync_d_d;
      wr_x_q      <= wr_x_d;
      wr_y_q      <= wr_y_d;
      wr_ptr_q    <= wr_ptr_d;
      drop_line_q <= drop_line_d;
      rd_x_q      <= rd_x_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      error_q     <= error_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      rd_row_q    <= rd_row_d;
      tag_q       <= tag_d;
`ifdef FRAME_LINE_RING_DROP_CNT_EN
      drop_cnt_q  <= drop_cnt_d;
`endif
    end
  end

  assign ready    = (count_q != '0);
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign rd_row   = rd_row_q;
  assign busy     = (state_q != S_IDLE);
  assign error    = error_q;
`ifdef FRAME_LINE_RING_DROP_CNT_EN
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_frame_line_ring.sv
// Bench for frame_line_ring: line-queue reference model feeds an expected-pixel scoreboard drained by a monitor.
module tb_frame_line_ring;
  localparam int H = 8, V = 4, L = 2, DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, trig, vsync, de, read_en;
  logic [DW-1:0] din, rd_data;
  logic          ready, rd_valid, rd_last, busy, error;
  logic [1:0]    rd_row;
`ifdef FRAME_LINE_RING_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  frame_line_ring #(.H_ACT(H), .V_ACT(V), .DATA_W(DW), .LINES(L)) dut (
    .clk(clk), .rstn(rstn), .trig(trig), .vsync(vsync), .de(de), .din(din),
    .ready(ready), .read_en(read_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_last(rd_last), .rd_row(rd_row), .busy(busy),
`ifdef FRAME_LINE_RING_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .error(error)
  );

  int checks = 0, errors = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
    logic [1:0]    row;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: mode 0 idle, 1 waiting for frame start, 2 capturing, 3 draining.
  int m_mode, m_x, m_y, m_rd_idx;
  bit m_vs_prev, m_drop, m_err, m_rv;
  int m_cur[$];
  int m_ring_pix[$];
  int m_ring_row[$];
`ifdef FRAME_LINE_RING_DROP_CNT_EN
  int m_drops;
`endif
  bit rst_req = 1'b0;
  bit g_trig = 1'b0;
  bit g_chk_zero = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_x = 0; m_y = 0; m_rd_idx = 0;
    m_vs_prev = 0; m_drop = 0; m_err = 0; m_rv = 0;
    m_cur.delete(); m_ring_pix.delete(); m_ring_row.delete();
`ifdef FRAME_LINE_RING_DROP_CNT_EN
    m_drops = 0;
`endif
  endtask

  task automatic line_done();
    m_y++; m_x = 0; m_drop = 0; m_cur.delete();
    if (m_y == V) m_mode = 3;
  endtask

  task automatic model_step(input bit t, input bit vs, input bit d, input logic [DW-1:0] px, input bit re);
    int  cnt0;
    bit  vs_rise;
    exp_t e;
    cnt0 = m_ring_row.size();
    vs_rise = vs && !m_vs_prev;
    m_vs_prev = vs;
    m_rv = 0;
    if (re && cnt0 != 0) begin
      e.d = DW'(m_ring_pix.pop_front());
      e.row = 2'(m_ring_row[0]);
      m_rd_idx++;
      e.last = (m_rd_idx == H);
      if (e.last) begin
        void'(m_ring_row.pop_front());
        m_rd_idx = 0;
      end
      exp_q.push_back(e);
      m_rv = 1;
    end
    case (m_mode)
      0: if (t) begin
        m_mode = 1; m_err = 0;
`ifdef FRAME_LINE_RING_DROP_CNT_EN
        m_drops = 0;
`endif
      end
      1: if (vs_rise) begin
        m_mode = 2; m_x = 0; m_y = 0; m_drop = 0; m_cur.delete();
      end
      2: begin
        if (vs_rise) begin
          m_err = 1; m_mode = 3; m_x = 0; m_drop = 0; m_cur.delete();
        end else if (d) begin
          if (m_x == 0 && cnt0 == L) begin
            m_drop = 1; m_err = 1;
`ifdef FRAME_LINE_RING_DROP_CNT_EN
            if (m_drops < 65535) m_drops++;
`endif
          end
          if (!m_drop) m_cur.push_back(int'(px));
          m_x++;
          if (m_x == H) begin
            if (!m_drop) begin
              foreach (m_cur[i]) m_ring_pix.push_back(m_cur[i]);
              m_ring_row.push_back(m_y);
            end
            line_done();
          end
        end else if (m_x != 0) begin
          m_err = 1;
          line_done();
        end
      end
      default: if (cnt0 == 0) m_mode = 0;
    endcase
  endtask

  task automatic cyc(input bit t, input bit vs, input bit d, input logic [DW-1:0] px, input bit re);
    @(negedge clk);
    chk("ready", 32'(ready), 32'(m_ring_row.size() != 0));
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("error", 32'(error), 32'(m_err));
    chk("rd_valid", 32'(rd_valid), 32'(m_rv));
`ifdef FRAME_LINE_RING_DROP_CNT_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif
    if (g_chk_zero) begin
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_rd_row", 32'(rd_row), 32'd0);
      chk("rst_rd_last", 32'(rd_last), 32'd0);
      g_chk_zero = 1'b0;
    end
    rstn = !rst_req; trig = t; vsync = vs; de = d; din = px; read_en = re;
    if (rst_req) model_reset();
    else model_step(t, vs, d, px, re);
  endtask

  function automatic bit rr(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  task automatic frame(input int short_row, input int short_len, input int early_after,
                       input int pct, input bit rnd);
    int n;
    logic [DW-1:0] px;
    cyc(0, 1, 0, '0, rr(pct));
    cyc(0, 1, 0, '0, rr(pct));
    cyc(0, 0, 0, '0, rr(pct));
    for (int r = 0; r < V; r++) begin
      if (r == early_after) begin
        cyc(0, 1, 0, '0, rr(pct));
        cyc(0, 0, 0, '0, rr(pct));
        return;
      end
      repeat ($urandom_range(1, 3)) cyc(0, 0, 0, '0, rr(pct));
      n = (r == short_row) ? short_len : H;
      for (int x = 0; x < n; x++) begin
        px = rnd ? DW'($urandom) : DW'(r * H + x);
        cyc(g_trig && x == 0, 0, 1, px, rr(pct));
      end
    end
    cyc(0, 0, 0, '0, rr(pct));
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (!(m_mode == 0 && m_ring_row.size() == 0) && budget < 500) begin
      cyc(0, 0, 0, '0, 1'($urandom_range(0, 1)));
      budget++;
    end
    cyc(0, 0, 0, '0, 0);
    if (budget >= 500) begin
      checks++; errors++;
      $display("FAIL drain_timeout mode=%0d lines=%0d required idle", m_mode, m_ring_row.size());
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read data=%0h row=%0d required no output", rd_data, rd_row);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", 32'(rd_data), 32'(e.d));
          chk("rd_last", 32'(rd_last), 32'(e.last));
          chk("rd_row", 32'(rd_row), 32'(e.row));
        end
      end
    end
  end

  initial begin : stim
    rstn = 0; trig = 0; vsync = 0; de = 0; din = '0; read_en = 0;
    model_reset();
    repeat (3) @(posedge clk);
    g_chk_zero = 1'b1;

    // Basic capture, continuous reads
    cyc(1, 0, 0, '0, 0);
    frame(-1, 0, -1, 100, 0);
    drain();

    // Overflow: no reads during the frame
    cyc(1, 0, 0, '0, 0);
    frame(-1, 0, -1, 0, 0);
    chk("ovf_error", 32'(error), 32'd1);
    drain();

    // Short line on row 1
    cyc(1, 0, 0, '0, 0);
    frame(1, 5, -1, 100, 0);
    chk("short_error", 32'(error), 32'd1);
    drain();

    // Early vsync after two lines, then trig clears error
    cyc(1, 0, 0, '0, 0);
    frame(-1, 0, 2, 50, 0);
    drain();
    chk("early_error", 32'(error), 32'd1);
    cyc(1, 0, 0, '0, 0);
    cyc(0, 0, 0, '0, 0);
    chk("trig_clears_error", 32'(error), 32'd0);

    // Trig pulses in WAIT_VSYNC and CAPTURE are ignored
    cyc(1, 0, 0, '0, 0);
    g_trig = 1'b1;
    frame(-1, 0, -1, 30, 0);
    g_trig = 1'b0;
    drain();

    // Trig while vsync already high: no capture until a fresh rising edge
    cyc(0, 1, 0, '0, 0);
    cyc(1, 1, 0, '0, 0);
    for (int x = 0; x < H; x++) cyc(0, 1, 1, DW'(100 + x), 1);
    chk("vs_high_no_capture", 32'(ready), 32'd0);
    cyc(0, 0, 0, '0, 0);
    frame(-1, 0, -1, 60, 0);
    drain();

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      cyc(1, 0, 0, '0, 0);
      frame(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, V - 1)) : -1,
            int'($urandom_range(1, H - 1)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, V - 1)) : -1,
            int'($urandom_range(0, 100)), 1);
      drain();
    end

    // Reset mid-line with two lines stored
    cyc(1, 0, 0, '0, 0);
    cyc(0, 1, 0, '0, 0);
    cyc(0, 0, 0, '0, 0);
    for (int r = 0; r < 2; r++)
      for (int x = 0; x < H; x++) cyc(0, 0, 1, DW'($urandom), 0);
    for (int x = 0; x < 3; x++) cyc(0, 0, 1, DW'($urandom), 0);
    chk("pre_reset_ready", 32'(ready), 32'd1);
    rst_req = 1'b1;
    cyc(0, 0, 1, '0, 1);
    rst_req = 1'b0;
    g_chk_zero = 1'b1;
    cyc(0, 0, 0, '0, 1);
    cyc(0, 0, 0, '0, 1);
    chk("post_reset_busy", 32'(busy), 32'd0);
    repeat (3) cyc(0, 0, 0, '0, 0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_line_ring.md
# frame_line_ring

Single-clock, parametrised multi-line frame capture buffer for the camera/HDMI pixel path. On a trigger it arms, waits for the next frame start (vsync rising edge) and stores each active line of that frame into a ring of LINES line memories. A downstream consumer reads whole lines at its own pace, and each line is tagged with its frame row number. Lines arriving while the ring is full are dropped and flagged.

## Interface
- `H_ACT`, 1280, active pixels per line.
- `V_ACT`, 720, active lines per frame.
- `DATA_W`, 16, pixel width in bits.
- `LINES`, 4, ring depth in lines; power of two, ≥2.

- `clk` in 1: single clock for all logic.
- `rstn` in 1: reset, synchronous, active-low.
- `trig` in 1: capture request; sampled only in IDLE.
- `vsync` in 1: frame sync; rising edge marks frame start.
- `de` in 1: pixel valid.
- `din` in DATA_W: pixel data.
- `ready` out 1: at least one complete line is stored.
- `read_en` in 1: consume one pixel.
- `rd_data` out DATA_W: pixel data.
- `rd_valid` out 1: `rd_data` is valid this cycle.
- `rd_last` out 1: `rd_data` is the last pixel of its line.
- `rd_row` out $clog2(V_ACT): frame row of `rd_data`.
- `busy` out 1: state is not IDLE.
- `error` out 1: sticky error flag.
- `drop_cnt` out 16: count of dropped lines; present only with the macro enabled.

## Operation
- States: IDLE, WAIT_VSYNC, CAPTURE, DRAIN.
  - IDLE: `trig`=1 goes to WAIT_VSYNC. The same cycle clears `error` and `drop_cnt`. `trig` in any other state is ignored.
  - WAIT_VSYNC: a vsync rising edge (vsync & ~vsync_d) goes to CAPTURE. `wr_x`, `wr_y` and the write pointer reset to 0. `vsync` high at entry does not count as an edge.
  - CAPTURE: each `de` cycle writes `din` to slot `wr_ptr`, address `wr_x`, then increments `wr_x`.
  - Line commit: `de` with `wr_x`==H_ACT-1. Tag the slot with `wr_y`, advance `wr_ptr` (mod LINES), increment `count`, set `wr_x`=0, increment `wr_y`.
  - Full ring: if `count`==LINES on the first pixel of a line (`wr_x`==0), drop the whole line. Its pixels are not written, `wr_y` still increments, `error` is set and `drop_cnt` increments.
  - Short line: `de` falls with 0<`wr_x`<H_ACT. The line is abandoned (not committed), `wr_x`=0, `wr_y` increments and `error` is set.
  - After V_ACT lines (committed, dropped or abandoned), go to DRAIN and ignore further `de`.
  - A vsync rising edge in CAPTURE before V_ACT lines are seen sets `error` and goes to DRAIN. The partial line in progress is discarded.
  - DRAIN: when `count`==0, go to IDLE.
- Read side works in every state:
  - `ready` = (`count`!=0).
  - `read_en` with `ready` reads slot `rd_ptr` at address `rd_x`, then increments `rd_x`.
  - On `rd_x`==H_ACT-1: `rd_x`=0, `rd_ptr`++ and `count`--.
  - `read_en` without `ready` is ignored: no advance, `rd_valid` stays 0.
  - Commit and consume in the same cycle leave `count` unchanged.
- Storage: one inferred RAM of LINES·H_ACT × DATA_W words, with one write port and one registered read port. Address = slot·H_ACT + x.
- `count` is $clog2(LINES)+1 bits wide. `drop_cnt` saturates at 16'hFFFF.

## Timing
- Reset values: `ready`, `rd_valid`, `rd_last`, `busy` and `error` are 0; `rd_data`, `rd_row` and `drop_cnt` are 0; state is IDLE; all pointers and counters are 0.
- Read latency is 1: `read_en` accepted at cycle n gives `rd_data`/`rd_valid`/`rd_last`/`rd_row` at n+1.
- Write-to-ready latency is 1: a commit at cycle n asserts `ready` at n+1. A line committed at n can be read starting at n+1.
- `busy` rises the cycle after `trig` is accepted. It falls the cycle after DRAIN sees `count`==0.
- `error` is set the cycle after the triggering event. It holds until the next accepted `trig`.
- Reset asserted mid-capture or mid-read takes effect at the next clk edge and discards all stored lines.

## Configuration
- `FRAME_LINE_RING_DROP_CNT_EN`:
  - Defined: `drop_cnt` port and its 16-bit saturating counter exist.
  - Undefined: neither the port nor the counter exists. Dropped lines still set `error`.

## Test plan
- Basic capture: H_ACT=8, V_ACT=4, LINES=4. `trig`, vsync edge, 4 lines of pixels 0..31, reading continuously. Expect `rd_data` 0..31 in order, `rd_row` 0,0,…,3, `rd_last` on pixels 7/15/23/31, `error`=0, `busy` falling after DRAIN.
- Overflow: LINES=2, no reads during a 4-line frame. Expect rows 0 and 1 stored, rows 2 and 3 dropped, `error`=1, `drop_cnt`=2. Later reads return rows 0 then 1 only.
- Short line: `de` drops after 5 of 8 pixels on row 1. Expect row 1 never readable, rows 0, 2, 3 tagged correctly, `error`=1.
- Early vsync: second vsync edge after 2 of 4 lines. Expect DRAIN with 2 lines readable, then IDLE, `error`=1. A following `trig` clears `error`.
- Trig gating: `trig` pulses in WAIT_VSYNC and CAPTURE. Expect no restart and no counter clear. `trig` before any vsync edge with `vsync` held high: no capture until the next rising edge.
- Reset: `rstn`=0 mid-line with `count`=2. The next cycle shows all outputs at reset values, `ready`=0 and state IDLE.
